// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction/data) to one-slave memory bus arbiter with
// round-robin or data-first arbitration and a bus-timeout watchdog.
module mem_bus_arbiter #(
    parameter bit          RR_EN          = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,

    output logic        err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_lastGntD;
    logic        r_mValid;
    logic [31:0] r_mAddr;
    logic [31:0] r_mWdata;
    logic [3:0]  r_mWstrb;
    logic        r_err;
    logic [31:0] r_errAddr;
    logic [15:0] r_wdCnt;

    logic w_granted;
    logic w_toHit;
    logic w_done;
    logic w_pickD;

    // Gating with resetn keeps both ready strobes quiet while reset is held.
    assign w_granted = resetn && (r_state != IDLE);
    assign w_toHit   = TO_EN && w_granted && (r_wdCnt == TO_LAST) && !m_ready;
    assign w_done    = w_granted && (m_ready || w_toHit);
    assign w_pickD   = d_valid && (!i_valid || !RR_EN || !r_lastGntD);

    assign i_ready = w_done && (r_state == GNT_I);
    assign d_ready = w_done && (r_state == GNT_D);
    // A timeout completes with m_ready low, so only a real completion forwards data.
    assign i_rdata = (i_ready && m_ready) ? m_rdata : 32'h0;
    assign d_rdata = (d_ready && m_ready) ? m_rdata : 32'h0;

    assign m_valid  = r_mValid;
    assign m_addr   = r_mAddr;
    assign m_wdata  = r_mWdata;
    assign m_wstrb  = r_mWstrb;
    assign err      = r_err;
    assign err_addr = r_errAddr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_lastGntD <= 1'b0;
            r_mValid   <= 1'b0;
            r_mAddr    <= 32'h0;
            r_mWdata   <= 32'h0;
            r_mWstrb   <= 4'h0;
            r_err      <= 1'b0;
            r_errAddr  <= 32'h0;
            r_wdCnt    <= 16'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid || d_valid) begin
                        r_mAddr  <= w_pickD ? d_addr  : i_addr;
                        r_mWdata <= w_pickD ? d_wdata : i_wdata;
                        r_mWstrb <= w_pickD ? d_wstrb : i_wstrb;
                        r_mValid <= 1'b1;
                        r_wdCnt  <= 16'h0;
                        r_state  <= w_pickD ? GNT_D : GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    if (w_done) begin
                        r_mValid   <= 1'b0;
                        r_lastGntD <= (r_state == GNT_D);
                        r_state    <= IDLE;
                        if (w_toHit) begin
                            r_err     <= 1'b1;
                            r_errAddr <= r_mAddr;
                        end
                    end else begin
                        r_wdCnt <= r_wdCnt + 16'h1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_mValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
